s2t_stream: RTL and testbench

- Receive-side inverse of the t2s coefficient reordering.
- Collects a 32-element vector as LANES-wide beats over a valid/ready stream, applies the inverse t2s permutation (for runtime-selected N window / depth), and presents the restored vector on a registered, back-pressurable output.
- Sits after the SAUS input-selection stage, returning coefficients to transform order.
- Double-buffered: the next frame's collection overlaps the output hold.

---
 rtl/s2t_pkg.sv | 38 +++
 rtl/s2t_perm.sv | 26 ++
 rtl/s2t_stream.sv | 114 +++++++++++
 tb/tb_s2t_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2t_pkg.sv
// s2t_pkg: shared definitions for the s2t (inverse t2s) coefficient reorder.
//   VEC_LEN     - fixed vector length handled by the t2s/s2t pair
//   coef_vec_t  - full vector of signed coefficients at the default width
//   t2s_index   - forward t2s map f(pos) for group size n and depth
//   max_depth   - largest depth that keeps the active window L >= n
package s2t_pkg;

    localparam int VEC_LEN = 32;
    localparam int COEF_W  = 16;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [VEC_LEN-1:0]      coef_vec_t;

    // Forward map: positions inside the window L = VEC_LEN >> depth are
    // interleaved within groups of n; the first half of each group takes
    // pairs from the front, the second half takes pairs from the back.
    // Positions outside the window pass straight through.
    function automatic int t2s_index(input int pos, input int n, input int depth);
        int r;
        int p;
        int base;
        if (pos >= (VEC_LEN >> depth)) return pos;
        r    = pos % n;
        p    = r % 2;
        base = (pos / n) * n;
        if (((pos / (n / 2)) % 2) == 0) return base + 2 * r - p;
        return base + n - 1 - 2 * (r - p - n / 2) - (1 - p);
    endfunction

    // log2(VEC_LEN / n): deepest setting where the window still spans a group.
    function automatic int max_depth(input int n);
        int d;
        d = 0;
        while ((n << d) < VEC_LEN) d++;
        return d;
    endfunction

endpackage

// File: rtl/s2t_perm.sv
// s2t_perm: combinational inverse-t2s permutation of one full vector.
//   vec_in  - collected vector in t2s order
//   depth   - clamped depth; window L = VEC_LEN >> depth
//   vec_out - vec_out[pos] = vec_in[f(pos)] inside the window, else vec_in[pos]
module s2t_perm
    import s2t_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 32
) (
    input  logic [VEC_LEN-1:0][WIDTH-1:0] vec_in,
    input  logic [2:0]                    depth,
    output logic [VEC_LEN-1:0][WIDTH-1:0] vec_out
);

    // The in-window source index is a per-position constant; depth only
    // decides whether a position is inside the window, so each output is a
    // 2:1 mux rather than a full 32:1 crossbar.
    for (genvar pos = 0; pos < VEC_LEN; pos++) begin : g_pos
        localparam int SRC = t2s_index(pos, N, 0);
        logic in_window;
        assign in_window    = (pos < (VEC_LEN >> depth));
        assign vec_out[pos] = in_window ? vec_in[SRC] : vec_in[pos];
    end

endmodule

// File: rtl/s2t_stream.sv
// s2t_stream: collects a 32-coefficient vector as LANES-wide beats, undoes
// the t2s reorder and presents the restored vector on a registered,
// back-pressurable output. Collection of the next frame overlaps the hold
// of the current output; only the final beat of a frame can stall.
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - beat valid;   in_ready - beat accepted when both high
//   in_data     - beat k carries collected[k*LANES + j] on lane j
//   in_last     - final-beat marker (checked against the beat count only)
//   in_depth    - frame depth, sampled on beat 0
//   out_valid   - restored vector valid; out_ready - downstream accept
//   out_vector  - restored vector;  out_depth - clamped depth used
//   err         - sticky framing error (in_last on the wrong beat)
module s2t_stream
    import s2t_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 32,
    parameter int LANES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [LANES-1:0][WIDTH-1:0]   in_data,
    input  logic                                 in_last,
    input  logic        [2:0]                    in_depth,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [VEC_LEN-1:0][WIDTH-1:0] out_vector,
    output logic        [2:0]                    out_depth,
    output logic                                 err
);

    localparam int               BEATS     = VEC_LEN / LANES;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]       MAX_D     = 3'(max_depth(N));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]              beat_cnt;
    logic [2:0]                    depth_q;
    logic [LANES-1:0][WIDTH-1:0]   beat_buf [2**CNT_W];
    logic [VEC_LEN-1:0][WIDTH-1:0] frame_vec;
    logic [VEC_LEN-1:0][WIDTH-1:0] perm_vec;
    logic                          last_beat;
    logic                          accept;
    logic                          done;
    logic [2:0]                    beat_depth;
    logic [2:0]                    frame_depth;

    assign last_beat = (beat_cnt == LAST_BEAT);

    // Only the completing beat needs a free output slot; a handshake in the
    // same cycle frees it, so full throughput holds with out_ready high.
    assign in_ready = !(last_beat && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign done     = accept && last_beat;

    // Clamp so the active window never becomes smaller than one group.
    assign beat_depth  = (in_depth > MAX_D) ? MAX_D : in_depth;
    // Single-beat frames complete on beat 0, before the latch can be used.
    assign frame_depth = (beat_cnt == '0) ? beat_depth : depth_q;

    // Collection storage needs no reset: every slot is rewritten each frame.
    always_ff @(posedge clk) begin
        if (accept) beat_buf[beat_cnt] <= in_data;
    end

    // The final beat is fed straight from the input so the permuted vector
    // can be registered on the same edge that accepts it.
    for (genvar b = 0; b < BEATS; b++) begin : g_frame
        if (b == BEATS - 1) begin : g_live
            assign frame_vec[b*LANES +: LANES] = in_data;
        end else begin : g_held
            assign frame_vec[b*LANES +: LANES] = beat_buf[b];
        end
    end

    s2t_perm #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_perm (
        .vec_in  (frame_vec),
        .depth   (frame_depth),
        .vec_out (perm_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            depth_q    <= '0;
            out_valid  <= 1'b0;
            out_vector <= '0;
            out_depth  <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0) depth_q <= beat_depth;
                // in_last is only audited; the beat count owns framing.
                if (in_last != last_beat) err <= 1'b1;
            end
            // A completing frame wins over a clear: a handshake and a new
            // frame in the same cycle keeps out_valid high with new data.
            if (done) begin
                out_valid  <= 1'b1;
                out_vector <= perm_vec;
                out_depth  <= frame_depth;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2t_stream.sv
module tb_s2t_stream;
    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int BEATS = 32 / LANES;

    typedef logic [31:0][WIDTH-1:0]    vec_t;
    typedef logic [LANES-1:0][WIDTH-1:0] beat_t;
    typedef struct { vec_t v32; vec_t v8; logic [2:0] d32; logic [2:0] d8; } exp_t;
    typedef struct { int pos; int exp32; int exp8; } ident_t;

    logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
    beat_t      in_data = '0;
    logic [2:0] in_depth = '0;
    logic       in_ready32, in_ready8, out_valid32, out_valid8, err32, err8;
    logic [2:0] out_depth32, out_depth8;
    vec_t       out_vector32, out_vector8;

    int n_vec = 0, n_fail = 0;
    bit rnd_mode = 0;

    always #5 clk = ~clk;

    s2t_stream #(.WIDTH(WIDTH), .N(32), .LANES(LANES)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_data(in_data), .in_last(in_last), .in_depth(in_depth),
        .out_valid(out_valid32), .out_ready(out_ready), .out_vector(out_vector32),
        .out_depth(out_depth32), .err(err32));

    s2t_stream #(.WIDTH(WIDTH), .N(8), .LANES(LANES)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_last(in_last), .in_depth(in_depth),
        .out_valid(out_valid8), .out_ready(out_ready), .out_vector(out_vector8),
        .out_depth(out_depth8), .err(err8));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---- reference model: pairs of the window are gathered group by group
    function automatic int ref_f(int pos, int n);
        int base = (pos / n) * n;
        int r    = pos % n;
        int h    = n / 2;
        int p    = r % 2;
        if (r < h) return base + 4 * (r / 2) + p;
        return base + n - 2 - 4 * ((r - h) / 2) + p;
    endfunction

    function automatic int eff_depth(int dep, int n);
        int md = $clog2(32 / n);
        return (dep > md) ? md : dep;
    endfunction

    function automatic vec_t model(vec_t coll, int dep, int n);
        vec_t o;
        int   l = 32 >> eff_depth(dep, n);
        for (int pos = 0; pos < 32; pos++) o[pos] = coll[(pos < l) ? ref_f(pos, n) : pos];
        return o;
    endfunction

    function automatic beat_t get_beat(vec_t v, int b);
        beat_t r;
        for (int j = 0; j < LANES; j++) r[j] = v[b*LANES + j];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 32; i++) v[i] = WIDTH'($urandom);
        return v;
    endfunction

    // ---- scoreboard: tracks accepted beats and the expected output queue
    exp_t q[$];
    exp_t m_e;
    vec_t m_coll;
    int   m_beat = 0;
    int   m_dep = 0;
    bit   err_exp = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_beat  = 0;
            err_exp = 0;
        end else begin
            chk("out_valid32", out_valid32, q.size() != 0);
            chk("out_valid8", out_valid8, q.size() != 0);
            if (q.size() != 0) begin
                chk("vec32", out_vector32, q[0].v32);
                chk("vec8", out_vector8, q[0].v8);
                chk("depth32", out_depth32, q[0].d32);
                chk("depth8", out_depth8, q[0].d8);
            end
            chk("in_ready32", in_ready32, !(m_beat == BEATS-1 && q.size() != 0 && !out_ready));
            chk("in_ready8", in_ready8, !(m_beat == BEATS-1 && q.size() != 0 && !out_ready));
            chk("err32", err32, err_exp);
            chk("err8", err8, err_exp);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && in_ready32) begin
                if (m_beat == 0) m_dep = int'(in_depth);
                for (int j = 0; j < LANES; j++) m_coll[m_beat*LANES + j] = in_data[j];
                if (in_last != (m_beat == BEATS-1)) err_exp = 1;
                if (m_beat == BEATS-1) begin
                    m_e.v32 = model(m_coll, m_dep, 32);
                    m_e.v8  = model(m_coll, m_dep, 8);
                    m_e.d32 = 3'(eff_depth(m_dep, 32));
                    m_e.d8  = 3'(eff_depth(m_dep, 8));
                    q.push_back(m_e);
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // ---- drivers
    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send_beat(input beat_t d, input logic last, input logic [2:0] dep);
        int guard = 0;
        in_valid = 1; in_data = d; in_last = last; in_depth = dep;
        while (!in_ready32 && guard < 40) begin
            step();
            guard++;
        end
        if (!in_ready32) chk("beat_timeout", 0, 1);
        step();
        in_valid = 0;
    endtask

    task automatic send_frame(input vec_t coll, input logic [2:0] dep, input int extra_last);
        for (int b = 0; b < BEATS; b++) begin
            if (rnd_mode) while ($urandom_range(0, 3) == 0) step();
            // depth on later beats must be ignored
            send_beat(get_beat(coll, b), (b == BEATS-1) || (b == extra_last),
                      (b == 0 || !rnd_mode) ? dep : 3'($urandom));
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst = 1;
        #1;
        chk("rst_valid32", out_valid32, 0);
        chk("rst_valid8", out_valid8, 0);
        chk("rst_vec32", out_vector32, 0);
        chk("rst_vec8", out_vector8, 0);
        chk("rst_depth32", out_depth32, 0);
        chk("rst_err32", err32, 0);
        chk("rst_err8", err8, 0);
        chk("rst_ready32", in_ready32, 1);
        step();
        step();
        rst = 0;
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        ident_t tbl[15];
        vec_t   coll, x, fa, fb;

        // collected[i] = i; expected source index for N=32 (clamped to depth 0)
        // and N=8 at depth 1 (window of 16, upper half identity)
        tbl = '{'{0, 0, 0}, '{1, 1, 1}, '{2, 4, 4}, '{3, 5, 5}, '{4, 8, 6},
                '{6, 12, 2}, '{7, 13, 3}, '{9, 17, 9}, '{11, 21, 13}, '{15, 29, 11},
                '{16, 30, 16}, '{17, 31, 17}, '{18, 26, 18}, '{30, 2, 30}, '{31, 3, 31}};

        do_reset();

        // identity frame: latency, table lookup, depth clamp
        out_ready = 0;
        for (int i = 0; i < 32; i++) coll[i] = WIDTH'(i);
        send_frame(coll, 3'd1, -1);
        chk("lat_valid", out_valid32, 1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("ident32_pos%0d", tbl[i].pos), out_vector32[tbl[i].pos], tbl[i].exp32);
            chk($sformatf("ident8_pos%0d", tbl[i].pos), out_vector8[tbl[i].pos], tbl[i].exp8);
        end
        chk("ident_depth32", out_depth32, 0);
        chk("ident_depth8", out_depth8, 1);
        chk("ident_err", err32, 0);
        out_ready = 1;
        step();
        chk("ident_clear", out_valid32, 0);

        // round trip: apply t2s (N=8, depth 1) in the bench, expect x back
        for (int k = 0; k < 3; k++) begin
            x = rand_vec();
            for (int pos = 0; pos < 32; pos++) coll[(pos < 16) ? ref_f(pos, 8) : pos] = x[pos];
            out_ready = 0;
            send_frame(coll, 3'd1, -1);
            chk("roundtrip8", out_vector8, x);
            out_ready = 1;
            step();
        end

        // back-pressure: frame A held, frame B stalls only on its last beat,
        // then A drains and B completes in the same cycle
        out_ready = 0;
        fa = rand_vec();
        fb = rand_vec();
        send_frame(fa, 3'd2, -1);
        for (int b = 0; b < BEATS-1; b++) begin
            chk("bp_ready_early", in_ready32, 1);
            send_beat(get_beat(fb, b), 0, 3'd0);
        end
        in_valid = 1; in_data = get_beat(fb, BEATS-1); in_last = 1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_stall", in_ready32, 0);
            chk("bp_hold32", out_vector32, model(fa, 2, 32));
            step();
        end
        out_ready = 1;
        #1;
        chk("bp_release", in_ready32, 1);
        step();
        in_valid = 0;
        chk("simul_valid", out_valid32, 1);
        chk("simul_vec32", out_vector32, model(fb, 0, 32));
        chk("simul_vec8", out_vector8, model(fb, 0, 8));
        step();
        chk("bp_drained", out_valid32, 0);

        // randomized streaming against the scoreboard
        rnd_mode = 1;
        for (int f = 0; f < 30; f++) send_frame(rand_vec(), 3'($urandom_range(0, 7)), -1);
        rnd_mode = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("rnd_drained", out_valid32, 0);

        // clamp and framing error: in_last on beat 3 as well as beat 7
        out_ready = 0;
        coll = rand_vec();
        for (int b = 0; b < BEATS; b++) begin
            send_beat(get_beat(coll, b), (b == 3) || (b == BEATS-1), 3'd3);
            if (b == 3) chk("err_set", err32, 1);
        end
        chk("clamp_valid", out_valid32, 1);
        chk("clamp_depth32", out_depth32, 0);
        chk("clamp_depth8", out_depth8, 2);
        out_ready = 1;
        step();
        step();
        chk("err_sticky", err32, 1);

        // reset mid-frame with an output held
        out_ready = 0;
        send_frame(rand_vec(), 3'd0, -1);
        for (int b = 0; b < 5; b++) send_beat(get_beat(coll, b), 0, 3'd1);
        do_reset();
        fa = rand_vec();
        send_frame(fa, 3'd1, -1);
        chk("fresh_vec32", out_vector32, model(fa, 1, 32));
        chk("fresh_vec8", out_vector8, model(fa, 1, 8));
        out_ready = 1;
        step();
        chk("fresh_clear", out_valid32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
